// File: rtl/c2sif_target.sv
// c2sif_target
//   Target side of the C-to-SV four-phase packet handshake. A packet offered
//   on req/id/fn/addr/data is latched once. It is then executed as
//   single-word beats on a simple memory-mapped bus. A signed status/result
//   is returned on ret, and the handshake completes on ack.
// Ports
//   clk, rst_n        block clock, asynchronous active-low reset
//   req / ack         four-phase packet handshake (req is asynchronous)
//   id, fn, addr      packet id (latched only), command {count, opcode},
//                     start byte address
//   data              DATA_SIZE write words, word i at [32*i +: 32]
//   ret               signed result, valid while ack = 1
//   bus_req/bus_we/bus_addr/bus_wdata   beat request towards the fabric
//   bus_ack/bus_err/bus_rdata           beat response (err wins over ack)
module c2sif_target #(
   parameter int DATA_SIZE = 8,
   parameter int TIMEOUT   = 255
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req,
   output logic                    ack,
   input  logic [31:0]             id,
   input  logic [31:0]             fn,
   input  logic [31:0]             addr,
   input  logic [32*DATA_SIZE-1:0] data,
   output logic [31:0]             ret,
   output logic                    bus_req,
   output logic                    bus_we,
   output logic [31:0]             bus_addr,
   output logic [31:0]             bus_wdata,
   input  logic                    bus_ack,
   input  logic                    bus_err,
   input  logic [31:0]             bus_rdata
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LATCH   = 3'd1,
      S_CHECK   = 3'd2,
      S_BUS     = 3'd3,
      S_GAP     = 3'd4,
      S_DONE    = 3'd5,
      S_WAITLOW = 3'd6
   } state_t;

   localparam logic [7:0]  OP_NOP     = 8'h00;
   localparam logic [7:0]  OP_WRITE   = 8'h01;
   localparam logic [7:0]  OP_READ    = 8'h02;
   localparam logic [7:0]  MAX_CNT    = 8'(DATA_SIZE);
   localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);
   localparam logic [31:0] RET_BADOP  = 32'hFFFF_FFFF;   // -1
   localparam logic [31:0] RET_BUSERR = 32'hFFFF_FFFE;   // -2
   localparam logic [31:0] RET_BADCNT = 32'hFFFF_FFFD;   // -3
   localparam logic [31:0] RET_ALIGN  = 32'hFFFF_FFFC;   // -4
   localparam logic [31:0] RET_TMO    = 32'hFFFF_FFFB;   // -5

   // Returns {needs_bus, ret}; ret is only meaningful when needs_bus = 0.
   function automatic logic [32:0] decode_cmd(input logic [31:0] f, input logic [31:0] a);
      logic [32:0] r;
      r = {1'b0, RET_BADOP};
      case (f[7:0])
         OP_NOP:   r = {1'b0, 32'h0000_0000};
         OP_WRITE: begin
            if ((f[15:8] == 8'd0) || (f[15:8] > MAX_CNT)) r = {1'b0, RET_BADCNT};
            else if (a[1:0] != 2'b00)                     r = {1'b0, RET_ALIGN};
            else                                          r = {1'b1, 32'h0000_0000};
         end
         OP_READ: begin
            if (a[1:0] != 2'b00) r = {1'b0, RET_ALIGN};
            else                 r = {1'b1, 32'h0000_0000};
         end
         default:  r = {1'b0, RET_BADOP};
      endcase
      return r;
   endfunction

   state_t                  state_q, state_d;
   logic                    req_meta_q, req_s_q;
   logic [31:0]             id_q, id_d, fn_q, fn_d, addr_q, addr_d;
   logic [32*DATA_SIZE-1:0] data_q, data_d;
   logic                    go_bus_q, go_bus_d;
   logic [7:0]              beat_q, beat_d;
   logic [15:0]             timer_q, timer_d;
   logic                    ack_q, ack_d;
   logic [31:0]             ret_q, ret_d;
   logic                    bus_req_q, bus_req_d, bus_we_q, bus_we_d;
   logic [31:0]             bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
   logic [32:0]             dec_s;
   logic [31:0]             word_s;
   logic                    unused_s;

   // id and the upper fn bits are carried for the driver but never interpreted
   assign unused_s = ^{id_q, fn_q[31:16]};

   // Select the write word for the current beat index
   always_comb begin
      word_s = 32'h0000_0000;
      for (int i = 0; i < DATA_SIZE; i++) begin
         if (beat_q == 8'(i)) word_s = data_q[32*i +: 32];
         else                 word_s = word_s;
      end
   end

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      fn_d        = fn_q;
      addr_d      = addr_q;
      data_d      = data_q;
      go_bus_d    = go_bus_q;
      beat_d      = beat_q;
      timer_d     = timer_q;
      ret_d       = ret_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      // Packet inputs are stable while req is high, so decoding them raw in LATCH is safe
      dec_s       = decode_cmd(fn, addr);
      case (state_q)
         S_IDLE: begin
            if (req_s_q) state_d = S_LATCH;
            else         state_d = S_IDLE;
         end
         S_LATCH: begin
            id_d     = id;
            fn_d     = fn;
            addr_d   = addr;
            data_d   = data;
            go_bus_d = dec_s[32];
            beat_d   = 8'd0;
            timer_d  = 16'd0;
            // No-bus results are registered here so ret leads ack by a cycle
            if (!dec_s[32]) ret_d = dec_s[31:0];
            else            ret_d = ret_q;
            state_d  = S_CHECK;
         end
         S_CHECK: begin
            if (go_bus_q) begin
               state_d    = S_BUS;
               bus_addr_d = addr_q;
               if (fn_q[7:0] == OP_WRITE) begin
                  bus_we_d    = 1'b1;
                  bus_wdata_d = data_q[31:0];
               end else begin
                  bus_we_d    = 1'b0;
                  bus_wdata_d = 32'h0000_0000;
               end
            end else begin
               state_d = S_DONE;
            end
         end
         S_BUS: begin
            if (bus_err) begin
               ret_d   = RET_BUSERR;
               state_d = S_DONE;
            end else if (bus_ack) begin
               if (!bus_we_q) begin
                  ret_d   = bus_rdata;
                  state_d = S_DONE;
               end else if (beat_q == (fn_q[15:8] - 8'd1)) begin
                  ret_d   = {24'h00_0000, fn_q[15:8]};
                  state_d = S_DONE;
               end else begin
                  beat_d  = beat_q + 8'd1;
                  state_d = S_GAP;
               end
            end else if (timer_q == TMO_LAST) begin
               ret_d   = RET_TMO;
               state_d = S_DONE;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         S_GAP: begin
            // beat_q already points at the next word; address wraps mod 2^32
            timer_d     = 16'd0;
            bus_addr_d  = bus_addr_q + 32'd4;
            bus_wdata_d = word_s;
            state_d     = S_BUS;
         end
         S_DONE: begin
            state_d = S_WAITLOW;
         end
         S_WAITLOW: begin
            if (!req_s_q) state_d = S_IDLE;
            else          state_d = S_WAITLOW;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      bus_req_d = (state_d == S_BUS);
      // No-bus packets raise ack on entering DONE; bus packets one edge after ret
      ack_d     = (state_d == S_WAITLOW) || ((state_q == S_CHECK) && (state_d == S_DONE));
   end

   // req synchronizer, FSM state and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_meta_q  <= 1'b0;
         req_s_q     <= 1'b0;
         state_q     <= S_IDLE;
         id_q        <= 32'h0000_0000;
         fn_q        <= 32'h0000_0000;
         addr_q      <= 32'h0000_0000;
         data_q      <= '0;
         go_bus_q    <= 1'b0;
         beat_q      <= 8'd0;
         timer_q     <= 16'd0;
         ack_q       <= 1'b0;
         ret_q       <= 32'h0000_0000;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'h0000_0000;
         bus_wdata_q <= 32'h0000_0000;
      end else begin
         req_meta_q  <= req;
         req_s_q     <= req_meta_q;
         state_q     <= state_d;
         id_q        <= id_d;
         fn_q        <= fn_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         go_bus_q    <= go_bus_d;
         beat_q      <= beat_d;
         timer_q     <= timer_d;
         ack_q       <= ack_d;
         ret_q       <= ret_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
      end
   end

   assign ack       = ack_q;
   assign ret       = ret_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_c2sif_target.sv
module tb_c2sif_target;
   localparam int DS  = 8;
   localparam int TMO = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            req = 1'b0;
   logic            ack;
   logic [31:0]     id = 32'd0, fn = 32'd0, addr = 32'd0;
   logic [32*DS-1:0] data = '0;
   logic [31:0]     ret;
   logic            bus_req, bus_we;
   logic [31:0]     bus_addr, bus_wdata;
   logic            bus_ack = 1'b0, bus_err = 1'b0;
   logic [31:0]     bus_rdata = 32'd0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          chk_wdata;
   } beat_t;

   beat_t       exp_beats[$];
   logic [31:0] exp_rets[$];

   // slave behaviour knobs
   int          slv_wait = 0;
   int          slv_err_beat = -1;
   bit          slv_dead = 1'b0;
   logic [31:0] slv_rdata = 32'd0;
   int          slv_beat_idx = 0;
   bit          in_beat = 1'b0;
   int          wait_cnt = 0;
   int          hold_cnt = 0;
   int          last_hold = 0;

   c2sif_target #(.DATA_SIZE(DS), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .id(id), .fn(fn), .addr(addr),
      .data(data), .ret(ret), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   // Bus slave: checks each new beat against the scoreboard and answers it
   always @(negedge clk) begin : slave
      beat_t e;
      bus_ack   = 1'b0;
      bus_err   = 1'b0;
      bus_rdata = 32'd0;
      if (bus_req === 1'b1) begin
         if (!in_beat) begin
            in_beat  = 1'b1;
            wait_cnt = 0;
            hold_cnt = 0;
            checks++;
            if (exp_beats.size() == 0) begin
               errors++;
               $display("FAIL beat_unexpected: got we=%b addr=%h, required no beat", bus_we, bus_addr);
            end else begin
               e = exp_beats.pop_front();
               if (bus_we !== e.we || bus_addr !== e.addr || (e.chk_wdata && bus_wdata !== e.wdata)) begin
                  errors++;
                  $display("FAIL beat_content: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                           bus_we, bus_addr, bus_wdata, e.we, e.addr, e.wdata);
               end
            end
            slv_beat_idx++;
         end
         hold_cnt++;
         if (!slv_dead && wait_cnt == slv_wait) begin
            if (slv_beat_idx - 1 == slv_err_beat) bus_err = 1'b1;
            else begin
               bus_ack   = 1'b1;
               bus_rdata = slv_rdata;
            end
         end
         wait_cnt++;
      end else begin
         if (in_beat) last_hold = hold_cnt;
         in_beat = 1'b0;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic beat_t mk_beat(input logic we, input logic [31:0] a, input logic [31:0] w);
      beat_t b;
      b.we = we; b.addr = a; b.wdata = w; b.chk_wdata = we;
      return b;
   endfunction

   // One four-phase packet: drive, wait ack, pop and check ret, release, wait ack low
   task automatic run_packet(input string name, input logic [31:0] f, input logic [31:0] a,
                             input logic [31:0] exp_ret,
                             output int first_n, output int last_n, output int ack_n);
      int n;
      bit got;
      logic [31:0] prev_ret, e;
      @(negedge clk);
      slv_beat_idx = 0;
      fn = f; addr = a; id = $urandom; req = 1'b1;
      exp_rets.push_back(exp_ret);
      first_n = -1; last_n = -1; ack_n = -1; got = 1'b0; prev_ret = ret; n = 0;
      while (!got && n < 200) begin
         @(negedge clk);
         n++;
         if (bus_req === 1'b1) begin
            if (first_n < 0) first_n = n;
            last_n = n;
         end
         if (ack === 1'b1) begin
            got = 1'b1; ack_n = n;
         end else begin
            prev_ret = ret;
         end
      end
      e = exp_rets.pop_front();
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s_ack_rise: got no ack in 200 cycles, required ack", name);
      end else begin
         checks++;
         if (ret !== e) begin
            errors++;
            $display("FAIL %s_ret: got %h, required %h", name, ret, e);
         end
         if (prev_ret !== e) begin
            errors++;
            $display("FAIL %s_ret_early: got %h one cycle before ack, required %h", name, prev_ret, e);
         end
      end
      req = 1'b0;
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (ack === 1'b0) got = 1'b1;
      end
      checks++;
      if (n != 3 || !got) begin
         errors++;
         $display("FAIL %s_ack_fall: got ack low after %0d cycles, required 3", name, n);
      end
      checks++;
      if (exp_beats.size() != 0) begin
         errors++;
         $display("FAIL %s_beats_missing: got %0d beats outstanding, required 0", name, exp_beats.size());
      end
      exp_beats.delete();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (ack !== 1'b0 || ret !== 32'd0 || bus_req !== 1'b0 || bus_we !== 1'b0 ||
          bus_addr !== 32'd0 || bus_wdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_values: got ack=%b ret=%h req=%b we=%b addr=%h wdata=%h, required all 0",
                  ack, ret, bus_req, bus_we, bus_addr, bus_wdata);
      end
   endtask

   task automatic test_write();
      int f, l, k;
      logic [31:0] w [3];
      w = '{32'h1111_AAAA, 32'h2222_BBBB, 32'h3333_CCCC};
      for (int i = 0; i < 3; i++) begin
         data[32*i +: 32] = w[i];
         exp_beats.push_back(mk_beat(1'b1, 32'h100 + 32'(4*i), w[i]));
      end
      run_packet("write3", 32'h0000_0301, 32'h0000_0100, 32'd3, f, l, k);
      checks++;
      if (f != 5 || (l - f + 1) != 5 || k != l + 2) begin
         errors++;
         $display("FAIL write3_timing: got first=%0d span=%0d ack=%0d, required 5 5 %0d", f, l - f + 1, k, l + 2);
      end
   endtask

   task automatic test_read();
      int f, l, k;
      slv_wait = 3; slv_rdata = 32'hDEAD_BEEF;
      exp_beats.push_back(mk_beat(1'b0, 32'h40, 32'd0));
      run_packet("read", 32'h0000_0002, 32'h0000_0040, 32'hDEAD_BEEF, f, l, k);
      checks++;
      if (f != 5 || l != 8 || k != 10) begin
         errors++;
         $display("FAIL read_timing: got first=%0d last=%0d ack=%0d, required 5 8 10", f, l, k);
      end
      slv_wait = 0; slv_rdata = 32'd0;
   endtask

   task automatic test_errors();
      int f, l, k;
      logic [31:0] efn [6], ead [6], eret [6];
      efn  = '{32'h0000_007F, 32'h0000_0001, 32'h0000_0102, 32'h0000_0901, 32'h0000_0101, 32'h0000_0000};
      ead  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0041, 32'h0000_0000, 32'h0000_0102, 32'h0000_0044};
      eret = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0000_0000};
      for (int i = 0; i < 6; i++) begin
         run_packet($sformatf("nobus%0d", i), efn[i], ead[i], eret[i], f, l, k);
         checks++;
         if (f != -1 || k != 5) begin
            errors++;
            $display("FAIL nobus%0d_timing: got first_req=%0d ack=%0d, required -1 5", i, f, k);
         end
      end
   endtask

   task automatic test_write_wrap();
      int f, l, k;
      logic [31:0] w;
      for (int i = 0; i < DS; i++) begin
         w = $urandom;
         data[32*i +: 32] = w;
         exp_beats.push_back(mk_beat(1'b1, 32'hFFFF_FFF8 + 32'(4*i), w));
      end
      run_packet("write8_wrap", 32'h0000_0801, 32'hFFFF_FFF8, 32'd8, f, l, k);
      checks++;
      if ((l - f + 1) != 15) begin
         errors++;
         $display("FAIL write8_span: got %0d cycles, required 15", l - f + 1);
      end
   endtask

   task automatic test_bus_err();
      int f, l, k;
      slv_err_beat = 1;
      for (int i = 0; i < 4; i++) data[32*i +: 32] = 32'hA000_0000 + 32'(i);
      exp_beats.push_back(mk_beat(1'b1, 32'h200, 32'hA000_0000));
      exp_beats.push_back(mk_beat(1'b1, 32'h204, 32'hA000_0001));
      run_packet("buserr", 32'h0000_0401, 32'h0000_0200, 32'hFFFF_FFFE, f, l, k);
      checks++;
      if (l != 7) begin
         errors++;
         $display("FAIL buserr_last_beat: got last bus_req cycle %0d, required 7", l);
      end
      slv_err_beat = -1;
   endtask

   task automatic test_timeout();
      int f, l, k;
      slv_dead = 1'b1;
      exp_beats.push_back(mk_beat(1'b0, 32'h80, 32'd0));
      run_packet("timeout", 32'h0000_0002, 32'h0000_0080, 32'hFFFF_FFFB, f, l, k);
      checks++;
      if (last_hold != TMO) begin
         errors++;
         $display("FAIL timeout_hold: got bus_req high %0d cycles, required %0d", last_hold, TMO);
      end
      slv_dead = 1'b0;
      run_packet("nop_after_tmo", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, f, l, k);
   endtask

   task automatic test_reset_mid();
      int f, l, k, n;
      slv_dead = 1'b1;
      data[31:0] = 32'h5555_0000; data[63:32] = 32'h5555_0001;
      exp_beats.push_back(mk_beat(1'b1, 32'h300, 32'h5555_0000));
      @(negedge clk);
      slv_beat_idx = 0;
      fn = 32'h0000_0201; addr = 32'h0000_0300; req = 1'b1;
      n = 0;
      while (bus_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus_req !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_beat_start: got no bus_req, required 1");
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (bus_req !== 1'b0 || ack !== 1'b0 || ret !== 32'd0 || bus_addr !== 32'd0) begin
         errors++;
         $display("FAIL rstmid_outputs: got req=%b ack=%b ret=%h addr=%h, required 0 0 0 0",
                  bus_req, ack, ret, bus_addr);
      end
      req = 1'b0; slv_dead = 1'b0;
      exp_beats.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      data[31:0] = 32'hCAFE_F00D;
      exp_beats.push_back(mk_beat(1'b1, 32'h0, 32'hCAFE_F00D));
      run_packet("write_after_rst", 32'h0000_0101, 32'h0000_0000, 32'd1, f, l, k);
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_errors();
      test_write_wrap();
      test_bus_err();
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
